// File: rtl/tlb_op_unit_pkg.sv
// Shared CPU definitions for the TLB maintenance path: entry layout, instruction
// encoding, FSM states and array size.
package CPU_Defines;

  localparam int TLBNUM = 16;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    TLBP  = 2'b00,
    TLBR  = 2'b01,
    TLBWI = 2'b10,
    TLBWR = 2'b11
  } tlb_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_READ,
    S_WRITE,
    S_DONE
  } tlb_state_t;

endpackage

// File: rtl/tlb_op_unit_random.sv
// CP0 Random register: free-running down-counter over [Wired, TLBNUM-1].
module tlb_random_counter #(
  parameter int TLBNUM = 16,
  parameter int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] wired,
  input  logic          wired_we,
  output logic [IW-1:0] random
);

  localparam logic [IW-1:0] RANDOM_MAX = IW'(TLBNUM - 1);

  // Reaching Wired (or 0) reloads the top, so Random never drops below Wired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      random <= RANDOM_MAX;
    end else if (wired_we) begin
      random <= RANDOM_MAX;
    end else if (random == wired || random == '0) begin
      random <= RANDOM_MAX;
    end else begin
      random <= random - 1'b1;
    end
  end

endmodule

// File: rtl/tlb_op_unit.sv
// TLB maintenance sequencer (TLBP/TLBR/TLBWI/TLBWR) for the MEM stage, driving the
// write/read side of the TLB array and returning results to CP0.
module tlb_op_unit
  import CPU_Defines::*;
#(
  parameter int TLBNUM = 16,
  parameter int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic [1:0]    op_type,
  output logic          op_ready,
  output logic          op_done,
  input  logic [IW-1:0] cp0_index,
  input  tlb_entry_t    cp0_entry,
  input  logic [IW-1:0] cp0_wired,
  input  logic          cp0_wired_we,
  output logic [IW-1:0] cp0_random,
  output logic [18:0]   s_vpn2,
  output logic [7:0]    s_asid,
  input  logic          s_found,
  input  logic [IW-1:0] s_index,
  output logic [IW-1:0] r_index,
  input  tlb_entry_t    r_entry,
  output logic          we,
  output logic [IW-1:0] w_index,
  output tlb_entry_t    w_entry,
  output logic          probe_we,
  output logic          probe_miss,
  output logic [IW-1:0] probe_index,
  output logic          read_we,
  output tlb_entry_t    read_entry,
  output logic          flush_req
);

  tlb_state_t    state, state_next;
  tlb_op_t       op_q;
  logic [IW-1:0] index_q;
  logic [IW-1:0] random_q;
  tlb_entry_t    entry_q;
  tlb_entry_t    read_q;
  logic          found_q;
  logic [IW-1:0] hit_idx_q;

  logic accept;
  assign accept = (state == S_IDLE) && op_valid;

  tlb_random_counter #(
    .TLBNUM(TLBNUM),
    .IW    (IW)
  ) u_random (
    .clk     (clk),
    .rst     (rst),
    .wired   (cp0_wired),
    .wired_we(cp0_wired_we),
    .random  (cp0_random)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Random is captured at accept, so a coincident Wired write cannot affect TLBWR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= TLBP;
      index_q   <= '0;
      random_q  <= '0;
      entry_q   <= '0;
      read_q    <= '0;
      found_q   <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      if (accept) begin
        op_q     <= tlb_op_t'(op_type);
        index_q  <= cp0_index;
        random_q <= cp0_random;
        entry_q  <= cp0_entry;
      end
      if (state == S_PROBE) begin
        found_q   <= s_found;
        hit_idx_q <= s_index;
      end
      if (state == S_READ) read_q <= r_entry;
    end
  end

  // The entry's g bit already carries EntryLo0.G & EntryLo1.G as assembled by CP0.
  always_comb begin
    state_next  = state;
    op_ready    = 1'b0;
    op_done     = 1'b0;
    s_vpn2      = '0;
    s_asid      = '0;
    r_index     = '0;
    we          = 1'b0;
    w_index     = '0;
    w_entry     = '0;
    probe_we    = 1'b0;
    probe_miss  = 1'b0;
    probe_index = '0;
    read_we     = 1'b0;
    read_entry  = '0;
    flush_req   = 1'b0;
    unique case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          unique case (tlb_op_t'(op_type))
            TLBP:        state_next = S_PROBE;
            TLBR:        state_next = S_READ;
            TLBWI, TLBWR: state_next = S_WRITE;
            default:     state_next = S_IDLE;
          endcase
        end
      end
      S_PROBE: begin
        s_vpn2     = entry_q.vpn2;
        s_asid     = entry_q.asid;
        state_next = S_DONE;
      end
      S_READ: begin
        r_index    = index_q;
        state_next = S_DONE;
      end
      S_WRITE: begin
        we         = 1'b1;
        w_index    = (op_q == TLBWR) ? random_q : index_q;
        w_entry    = entry_q;
        state_next = S_DONE;
      end
      S_DONE: begin
        op_done    = 1'b1;
        state_next = S_IDLE;
        unique case (op_q)
          TLBP: begin
            probe_we    = 1'b1;
            probe_miss  = ~found_q;
            probe_index = found_q ? hit_idx_q : '0;
          end
          TLBR: begin
            read_we    = 1'b1;
            read_entry = read_q;
          end
          default: flush_req = 1'b1;
        endcase
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_op_unit.sv
// Self-checking bench for tlb_op_unit: a behavioural TLB array around the DUT plus a
// reference model of TLB contents and the Random register.
module tb_tlb_op_unit;
  import CPU_Defines::*;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk, rst;
  logic          op_valid;
  logic [1:0]    op_type;
  logic          op_ready, op_done;
  logic [IW-1:0] cp0_index;
  tlb_entry_t    cp0_entry;
  logic [IW-1:0] cp0_wired;
  logic          cp0_wired_we;
  logic [IW-1:0] cp0_random;
  logic [18:0]   s_vpn2;
  logic [7:0]    s_asid;
  logic          s_found;
  logic [IW-1:0] s_index;
  logic [IW-1:0] r_index;
  tlb_entry_t    r_entry;
  logic          we;
  logic [IW-1:0] w_index;
  tlb_entry_t    w_entry;
  logic          probe_we, probe_miss;
  logic [IW-1:0] probe_index;
  logic          read_we;
  tlb_entry_t    read_entry;
  logic          flush_req;

  int checks = 0;
  int errors = 0;

  tlb_op_unit #(.TLBNUM(N), .IW(IW)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
    .op_ready(op_ready), .op_done(op_done), .cp0_index(cp0_index),
    .cp0_entry(cp0_entry), .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we),
    .cp0_random(cp0_random), .s_vpn2(s_vpn2), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .r_index(r_index), .r_entry(r_entry),
    .we(we), .w_index(w_index), .w_entry(w_entry), .probe_we(probe_we),
    .probe_miss(probe_miss), .probe_index(probe_index), .read_we(read_we),
    .read_entry(read_entry), .flush_req(flush_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tlb_entry_t init_entry(int i);
    tlb_entry_t e;
    e      = '0;
    e.vpn2 = 19'h01000 + 19'(i);
    e.asid = 8'(i);
    e.pfn0 = 20'h00100 + 20'(i);
    e.pfn1 = 20'h00200 + 20'(i);
    e.v0   = 1'b1;
    e.v1   = 1'b1;
    return e;
  endfunction

  function automatic tlb_entry_t rand_entry();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[77:0];
  endfunction

  // Array environment: what the DUT's ports actually talk to.
  tlb_entry_t env_tlb [N];
  logic       load_tlb;

  always @(posedge clk) begin
    if (load_tlb) begin
      for (int i = 0; i < N; i++) env_tlb[i] <= init_entry(i);
    end else if (we) begin
      env_tlb[w_index] <= w_entry;
    end
  end

  always_comb begin
    s_found = 1'b0;
    s_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (env_tlb[i].vpn2 == s_vpn2 && (env_tlb[i].g || env_tlb[i].asid == s_asid)) begin
        s_found = 1'b1;
        s_index = IW'(i);
      end
    end
  end

  assign r_entry = env_tlb[r_index];

  // Reference model: expected TLB contents and Random value.
  tlb_entry_t ref_tlb [N];
  int         m_rand;
  bit         rand_chk = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst)                                          m_rand <= N - 1;
    else if (cp0_wired_we)                             m_rand <= N - 1;
    else if (m_rand == int'(cp0_wired) || m_rand == 0) m_rand <= N - 1;
    else                                               m_rand <= m_rand - 1;
  end

  task automatic checkOutput(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && rand_chk) checkOutput("random", 78'(cp0_random), 78'(m_rand));
  end

  function automatic void ref_probe(input logic [18:0] v, input logic [7:0] a,
                                    output bit hit, output int idx);
    hit = 0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      if (!hit && ref_tlb[i].vpn2 == v && (ref_tlb[i].g || ref_tlb[i].asid == a)) begin
        hit = 1;
        idx = i;
      end
    end
  endfunction

  // Issues one instruction; must be called just after a negedge with the unit idle.
  task automatic applyStimulus(input tlb_op_t op, input logic [IW-1:0] idx,
                               input tlb_entry_t ent, input bit wired_pulse,
                               input logic [IW-1:0] new_wired);
    int  snap_rand;
    int  exp_widx;
    bit  is_wr;
    bit  hit;
    int  hit_idx;
    checkOutput("ready_before", 78'(op_ready), 78'(1));
    op_valid  = 1'b1;
    op_type   = op;
    cp0_index = idx;
    cp0_entry = ent;
    if (wired_pulse) begin
      cp0_wired_we = 1'b1;
      cp0_wired    = new_wired;
    end
    snap_rand = m_rand;
    is_wr     = (op == TLBWI) || (op == TLBWR);
    exp_widx  = (op == TLBWI) ? int'(idx) : snap_rand;
    ref_probe(ent.vpn2, ent.asid, hit, hit_idx);
    @(posedge clk); #1;
    op_valid     = 1'b0;
    cp0_wired_we = 1'b0;
    cp0_index    = IW'($urandom());
    cp0_entry    = rand_entry();
    checkOutput("ready_busy", 78'(op_ready), 78'(0));
    checkOutput("we", 78'(we), 78'(is_wr));
    checkOutput("done_early", 78'(op_done), 78'(0));
    if (is_wr) begin
      checkOutput("w_index", 78'(w_index), 78'(exp_widx));
      checkOutput("w_entry", w_entry, ent);
      ref_tlb[exp_widx] = ent;
    end else if (op == TLBP) begin
      checkOutput("s_vpn2", 78'(s_vpn2), 78'(ent.vpn2));
      checkOutput("s_asid", 78'(s_asid), 78'(ent.asid));
    end else begin
      checkOutput("r_index", 78'(r_index), 78'(idx));
    end
    @(posedge clk); #1;
    checkOutput("op_done", 78'(op_done), 78'(1));
    checkOutput("we_done", 78'(we), 78'(0));
    checkOutput("flush_req", 78'(flush_req), 78'(is_wr));
    checkOutput("probe_we", 78'(probe_we), 78'(op == TLBP));
    checkOutput("read_we", 78'(read_we), 78'(op == TLBR));
    if (op == TLBP) begin
      checkOutput("probe_miss", 78'(probe_miss), 78'(!hit));
      checkOutput("probe_index", 78'(probe_index), 78'(hit ? hit_idx : 0));
    end
    if (op == TLBR) checkOutput("read_entry", read_entry, ref_tlb[idx]);
    @(posedge clk); #1;
    checkOutput("ready_after", 78'(op_ready), 78'(1));
    checkOutput("done_after", 78'(op_done), 78'(0));
    checkOutput("flush_after", 78'(flush_req), 78'(0));
  endtask

  initial begin
    tlb_entry_t e;
    int         waited;
    rst          = 1'b0;
    load_tlb     = 1'b1;
    op_valid     = 1'b0;
    op_type      = 2'b00;
    cp0_index    = '0;
    cp0_entry    = '0;
    cp0_wired    = '0;
    cp0_wired_we = 1'b0;
    for (int i = 0; i < N; i++) ref_tlb[i] = init_entry(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    load_tlb = 1'b0;
    rst      = 1'b1;
    #1;
    checkOutput("rst_ready", 78'(op_ready), 78'(1));
    checkOutput("rst_random", 78'(cp0_random), 78'(15));
    checkOutput("rst_outs", 78'({we, op_done, probe_we, read_we, flush_req, probe_miss}), 78'(0));
    checkOutput("rst_w_entry", w_entry, 78'(0));
    checkOutput("rst_read_entry", read_entry, 78'(0));
    checkOutput("rst_s_vpn2", 78'(s_vpn2), 78'(0));
    rand_chk = 1;

    for (int k = 0; k < 18; k++) begin
      checkOutput("rand_seq", 78'(cp0_random), 78'((15 - k) & 15));
      @(negedge clk);
    end

    e      = rand_entry();
    e.vpn2 = 19'h00040;
    e.asid = 8'h12;
    e.g    = 1'b1 & 1'b0;
    applyStimulus(TLBWI, 4'd5, e, 0, '0);
    checkOutput("tlbwi_g", 78'(env_tlb[5].g), 78'(0));

    @(negedge clk);
    applyStimulus(TLBP, 4'd0, e, 0, '0);
    checkOutput("probe_hit_idx", 78'(probe_index), 78'(0));
    @(negedge clk);
    e.vpn2 = 19'h7FFFF;
    applyStimulus(TLBP, 4'd0, e, 0, '0);
    @(negedge clk);
    applyStimulus(TLBR, 4'd5, rand_entry(), 0, '0);

    @(negedge clk);
    cp0_wired    = 4'd4;
    cp0_wired_we = 1'b1;
    @(negedge clk);
    cp0_wired_we = 1'b0;
    waited = 0;
    while (m_rand != 4 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("wait_rand4", 78'(waited < 40), 78'(1));
    checkOutput("rand_is4", 78'(cp0_random), 78'(4));
    applyStimulus(TLBWR, 4'd9, rand_entry(), 0, '0);
    checkOutput("tlbwr_landed", env_tlb[4], ref_tlb[4]);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checkOutput("rand_ge_wired", 78'(cp0_random >= 4'd4), 78'(1));
    end

    for (int n = 0; n < 40; n++) begin
      tlb_op_t op;
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op     = tlb_op_t'($urandom_range(0, 3));
      e      = rand_entry();
      e.vpn2 = 19'h00040 + 19'($urandom_range(0, 3));
      e.asid = 8'h12 + 8'($urandom_range(0, 1));
      applyStimulus(op, IW'($urandom()), e, ($urandom_range(0, 3) == 0),
                    IW'($urandom_range(0, 7)));
    end

    @(negedge clk);
    op_valid  = 1'b1;
    op_type   = TLBWI;
    cp0_index = 4'd7;
    cp0_entry = rand_entry();
    @(posedge clk); #1;
    op_valid = 1'b0;
    checkOutput("mid_we", 78'(we), 78'(1));
    rst = 1'b0;
    #1;
    checkOutput("mid_we_reset", 78'(we), 78'(0));
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("post_rst_quiet",
                  78'({op_done, flush_req, we, probe_we, read_we}), 78'(0));
      checkOutput("post_rst_ready", 78'(op_ready), 78'(1));
      @(negedge clk);
    end
    checkOutput("no_write_after_rst", env_tlb[7], ref_tlb[7]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
